// File: rtl/sysid_pkg.sv
// System-ID slave shared constants.
// Register offsets, CONTROL/STATUS bit indices, uptime width.
package sysid_pkg;

  localparam int UPTIME_W = 64;

  localparam int OFF_ID    = 0;
  localparam int OFF_TS    = 1;
  localparam int OFF_UP_LO = 2;
  localparam int OFF_UP_HI = 3;
  localparam int OFF_CTRL  = 4;
  localparam int OFF_STAT  = 5;
  localparam int OFF_SCR0  = 6;

  localparam int CTRL_FREEZE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_WRAP = 0;

endpackage

// File: rtl/sysid_read_pipe.sv
// Read-return delay line: {valid, data} word, DEPTH register stages.
// Ports: clk, rst_n, in_word (msb = valid), out_word (msb = valid).
module sysid_read_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_word,
  output logic [W-1:0] out_word
);

  logic [W-1:0] stg [DEPTH];

  // Data only moves with its valid bit, so the last
  // stage holds the previous return between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0][W-1] <= in_word[W-1];
      if (in_word[W-1]) begin
        stg[0][W-2:0] <= in_word[W-2:0];
      end
      for (int i = 1; i < DEPTH; i++) begin
        stg[i][W-1] <= stg[i-1][W-1];
        if (stg[i-1][W-1]) begin
          stg[i][W-2:0] <= stg[i-1][W-2:0];
        end
      end
    end
  end

  assign out_word = stg[DEPTH-1];

endmodule

// File: rtl/nios2_sysid_ctrl.sv
// Avalon-MM system-ID slave: ID/TS, 64-bit uptime, status, scratch.
// Ports: clock, reset_n, address/read/write/writedata, readdata(valid), wrap_irq.
module nios2_sysid_ctrl
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYS_ID       = 32'h0,
  parameter logic [31:0] TIMESTAMP    = 32'h0,
  parameter int          NUM_SCRATCH  = 2,
  parameter int          READ_LATENCY = 1,
  parameter int          ADDR_W       = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              wrap_irq
);

  localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  logic [UPTIME_W-1:0] uptime;
  logic [31:0]         snap;
  logic                freeze;
  logic                irq_en;
  logic                wrap;
  logic [31:0]         scratch [SCR_N];

  logic        rd_acc;
  logic        sel_id;
  logic        sel_ts;
  logic        sel_lo;
  logic        sel_hi;
  logic        sel_ctrl;
  logic        sel_stat;
  logic        clr_wr;
  logic        w1c;
  logic        wrap_evt;
  logic [31:0] scr_rd;
  logic [31:0] rd_data;
  logic [32:0] pipe_out;

  // A write beats a simultaneous read; that read returns nothing.
  assign rd_acc   = read & ~write;

  assign sel_id   = address == ADDR_W'(OFF_ID);
  assign sel_ts   = address == ADDR_W'(OFF_TS);
  assign sel_lo   = address == ADDR_W'(OFF_UP_LO);
  assign sel_hi   = address == ADDR_W'(OFF_UP_HI);
  assign sel_ctrl = address == ADDR_W'(OFF_CTRL);
  assign sel_stat = address == ADDR_W'(OFF_STAT);

  assign clr_wr   = write & sel_ctrl & writedata[CTRL_CLEAR];
  assign w1c      = write & sel_stat & writedata[STAT_WRAP];
  // A clear on the same edge pre-empts the wrap.
  assign wrap_evt = ~clr_wr & ~freeze & (&uptime);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime <= '0;
    end else if (clr_wr) begin
      uptime <= '0;
    end else if (!freeze) begin
      uptime <= uptime + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freeze <= 1'b0;
      irq_en <= 1'b0;
    end else if (write && sel_ctrl) begin
      freeze <= writedata[CTRL_FREEZE];
      irq_en <= writedata[CTRL_IRQ_EN];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrap <= 1'b0;
    end else if (wrap_evt) begin
      wrap <= 1'b1;
    end else if (w1c) begin
      wrap <= 1'b0;
    end
  end

  // High word frozen at the same edge the low word is sampled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap <= '0;
    end else if (rd_acc && sel_lo) begin
      snap <= uptime[63:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SCR_N; i++) begin
        scratch[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (write && address == ADDR_W'(OFF_SCR0 + i)) begin
          scratch[i] <= writedata;
        end
      end
    end
  end

  always_comb begin
    scr_rd = '0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (address == ADDR_W'(OFF_SCR0 + i)) begin
        scr_rd = scratch[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      sel_id:   rd_data = SYS_ID;
      sel_ts:   rd_data = TIMESTAMP;
      sel_lo:   rd_data = uptime[31:0];
      sel_hi:   rd_data = snap;
      sel_ctrl: rd_data = 32'({irq_en, 1'b0, freeze});
      sel_stat: rd_data = 32'(wrap);
      default:  rd_data = scr_rd;
    endcase
  end

  sysid_read_pipe #(
    .DEPTH (READ_LATENCY),
    .W     (33)
  ) u_pipe (
    .clk      (clock),
    .rst_n    (reset_n),
    .in_word  ({rd_acc, rd_data}),
    .out_word (pipe_out)
  );

  assign readdatavalid = pipe_out[32];
  assign readdata      = pipe_out[31:0];
  assign wrap_irq      = wrap & irq_en;

endmodule

// File: tb/tb_nios2_sysid_ctrl.sv
// Bench for nios2_sysid_ctrl: directed scenarios plus random traffic.
// Reference model tracks uptime as anchor value plus elapsed cycles.
module tb_nios2_sysid_ctrl;

  localparam logic [31:0] SYS = 32'h5127F7FF;
  localparam logic [31:0] TS  = 32'h4C8A1B00;
  localparam int          LAT = 2;
  localparam logic [63:0] ONES = '1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        wrap_irq;

  nios2_sysid_ctrl #(
    .SYS_ID       (SYS),
    .TIMESTAMP    (TS),
    .NUM_SCRATCH  (2),
    .READ_LATENCY (LAT),
    .ADDR_W       (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .wrap_irq      (wrap_irq)
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] d;
    longint      due;
  } exp_t;
  exp_t q[$];

  // Model state: uptime(n) = base + (n - base_cyc) unless frozen.
  logic [63:0] m_base;
  longint      m_base_cyc;
  bit          m_frozen;
  bit          m_irq;
  bit          m_wrap;
  longint      m_pset;
  longint      m_pclr;
  logic [31:0] m_snap;
  logic [31:0] m_scr [2];
  logic [63:0] pre_v;

  function automatic logic [63:0] m_up(longint n);
    return m_frozen ? m_base : m_base + 64'(n - m_base_cyc);
  endfunction

  task automatic model_reset();
    m_base     = '0;
    m_base_cyc = cyc;
    m_frozen   = 0;
    m_irq      = 0;
    m_wrap     = 0;
    m_pset     = -1;
    m_pclr     = -1;
    m_snap     = '0;
    m_scr[0]   = '0;
    m_scr[1]   = '0;
    q.delete();
  endtask

  // Advance to next negedge; apply STATUS events due at that edge.
  task automatic step();
    @(negedge clock);
    if (m_pset == cyc) m_wrap = 1;
    else if (m_pclr == cyc) m_wrap = 0;
    if (m_pset <= cyc) m_pset = -1;
    if (m_pclr <= cyc) m_pclr = -1;
  endtask

  task automatic preload(input logic [63:0] v);
    pre_v = v;
    force dut.uptime = pre_v;
    #1;
    release dut.uptime;
    m_base     = v;
    m_base_cyc = cyc;
    if (!m_frozen && v == ONES) m_pset = cyc + 1;
  endtask

  task automatic bus(input bit rd, input bit wr,
                     input logic [3:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [63:0] u;
    longint      e1;
    if (rd && !wr) begin
      u = m_up(cyc);
      case (a)
        4'd0: e.d = SYS;
        4'd1: e.d = TS;
        4'd2: begin e.d = u[31:0]; m_snap = u[63:32]; end
        4'd3: e.d = m_snap;
        4'd4: e.d = {29'b0, m_irq, 1'b0, m_frozen};
        4'd5: e.d = {31'b0, m_wrap};
        4'd6: e.d = m_scr[0];
        4'd7: e.d = m_scr[1];
        default: e.d = '0;
      endcase
      e.due = cyc + LAT;
      q.push_back(e);
    end
    if (wr) begin
      e1 = cyc + 1;
      case (a)
        4'd4: begin
          u = wd[1] ? 64'd0 : m_up(e1);
          m_base     = u;
          m_base_cyc = e1;
          m_frozen   = wd[0];
          m_irq      = wd[2];
          if (wd[1] && m_pset == e1) m_pset = -1;
        end
        4'd5: if (wd[0]) m_pclr = e1;
        4'd6: m_scr[0] = wd;
        4'd7: m_scr[1] = wd;
        default: ;
      endcase
    end
    read      = rd;
    write     = wr;
    address   = a;
    writedata = wd;
  endtask

  task automatic idle();
    bus(0, 0, 4'd0, 32'd0);
  endtask

  // Scoreboard for every read return.
  always @(negedge clock) begin
    if (reset_n) begin
      if (readdatavalid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_errors++;
          $display("FAIL rd_unexpected cyc=%0d got=%h", cyc, readdata);
        end else begin
          if (q[0].due != cyc || readdata !== q[0].d) begin
            n_errors++;
            $display("FAIL rd_data cyc=%0d got=%h want=%h due=%0d",
                     cyc, readdata, q[0].d, q[0].due);
          end
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_missing cyc=%0d want=%h", cyc, q[0].d);
        void'(q.pop_front());
      end
    end
  end

  task automatic test_reset();
    model_reset();
    repeat (3) step();
    n_checks += 3;
    if (readdata !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_readdata got=%h want=0", readdata);
    end
    if (readdatavalid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_valid got=%b want=0", readdatavalid);
    end
    if (wrap_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_irq got=%b want=0", wrap_irq);
    end
    step();
    reset_n = 1'b1;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      step();
      bus(1, 0, 4'(a), 32'd0);
    end
    step();
    idle();
  endtask

  task automatic test_id_ts();
    step(); bus(1, 0, 4'd0, 32'd0);
    step(); bus(1, 0, 4'd1, 32'd0);
    step(); idle();
    n_checks++;
    if (readdatavalid !== 1'b1 || readdata !== SYS) begin
      n_errors++;
      $display("FAIL id_read got=%b/%h want=1/%h",
               readdatavalid, readdata, SYS);
    end
    step();
    n_checks++;
    if (readdatavalid !== 1'b1 || readdata !== TS) begin
      n_errors++;
      $display("FAIL ts_read got=%b/%h want=1/%h",
               readdatavalid, readdata, TS);
    end
  endtask

  task automatic test_atomic();
    logic [63:0] v;
    step(); preload(64'h0000_0001_FFFF_FFFF);
    bus(1, 0, 4'd2, 32'd0);
    step(); bus(1, 0, 4'd3, 32'd0);
    step(); idle();
    n_checks++;
    if (readdata !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL atomic_lo got=%h want=ffffffff", readdata);
    end
    step();
    n_checks++;
    if (readdata !== 32'h0000_0001) begin
      n_errors++;
      $display("FAIL atomic_hi got=%h want=00000001", readdata);
    end
    for (int i = 0; i < 6; i++) begin
      v = {$urandom, $urandom};
      step(); preload(v); bus(1, 0, 4'd2, 32'd0);
      step(); idle();
      step(); bus(1, 0, 4'd3, 32'd0);
    end
    step(); idle();
  endtask

  task automatic test_wrap();
    step(); bus(0, 1, 4'd4, 32'd4);
    step(); preload(ONES); bus(1, 0, 4'd2, 32'd0);
    step(); bus(1, 0, 4'd5, 32'd0);
    n_checks++;
    if (wrap_irq !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_irq_set got=%b want=1", wrap_irq);
    end
    step(); bus(0, 1, 4'd5, 32'd1);
    step(); bus(1, 0, 4'd2, 32'd0);
    n_checks++;
    if (wrap_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_irq_w1c got=%b want=0", wrap_irq);
    end
    // W1C on the wrap edge: set wins.
    step(); preload(ONES); bus(0, 1, 4'd5, 32'd1);
    step(); bus(1, 0, 4'd5, 32'd0);
    n_checks++;
    if (wrap_irq !== 1'b1) begin
      n_errors++;
      $display("FAIL wrap_vs_w1c got=%b want=1", wrap_irq);
    end
    step(); bus(0, 1, 4'd5, 32'd1);
    // Clear on the wrap edge: no wrap.
    step(); preload(ONES); bus(0, 1, 4'd4, 32'd6);
    step(); bus(1, 0, 4'd2, 32'd0);
    n_checks++;
    if (wrap_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_vs_clear got=%b want=0", wrap_irq);
    end
    step(); bus(1, 0, 4'd5, 32'd0);
    step(); bus(1, 0, 4'd3, 32'd0);
    step(); idle();
  endtask

  task automatic test_scratch();
    step(); bus(0, 1, 4'd6, 32'hDEADBEEF);
    step(); bus(0, 1, 4'd0, 32'h0);
    step(); bus(0, 1, 4'd7, $urandom);
    step(); bus(0, 1, 4'd15, 32'hFFFF_FFFF);
    step(); bus(1, 0, 4'd6, 32'd0);
    step(); bus(1, 0, 4'd0, 32'd0);
    step(); bus(1, 0, 4'd15, 32'd0);
    step(); bus(1, 0, 4'd7, 32'd0);
    step(); bus(1, 1, 4'd6, 32'h1234_5678);
    step(); bus(1, 0, 4'd6, 32'd0);
    step(); idle();
    step();
    step();
    n_checks++;
    if (readdata !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL scratch_rw got=%h want=12345678", readdata);
    end
  endtask

  task automatic test_freeze();
    step(); bus(0, 1, 4'd4, 32'd3);
    for (int i = 0; i < 100; i++) begin
      step(); bus(1, 0, (i % 2 == 0) ? 4'd2 : 4'd3, 32'd0);
    end
    step(); bus(1, 0, 4'd4, 32'd0);
    step(); idle();
    step();
    n_checks++;
    if (readdata !== 32'd1) begin
      n_errors++;
      $display("FAIL ctrl_read got=%h want=1", readdata);
    end
    step(); bus(0, 1, 4'd4, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(); bus(1, 0, 4'd2, 32'd0);
    end
    step(); idle();
  endtask

  task automatic test_random();
    bit          rd;
    bit          wr;
    logic [3:0]  a;
    logic [31:0] wd;
    for (int i = 0; i < 400; i++) begin
      rd = ($urandom % 3) != 0;
      wr = ($urandom % 4) == 0;
      a  = 4'($urandom % 16);
      wd = $urandom;
      step(); bus(rd, wr, a, wd);
    end
    step(); idle();
  endtask

  task automatic test_reset_mid();
    step(); bus(0, 1, 4'd4, 32'd4);
    step(); preload(ONES); bus(1, 0, 4'd0, 32'd0);
    step(); idle();
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (readdata !== 32'd0 || readdatavalid !== 1'b0 ||
        wrap_irq !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_async got=%h/%b/%b want=0/0/0",
               readdata, readdatavalid, wrap_irq);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (readdata !== 32'd0 || readdatavalid !== 1'b0 ||
          wrap_irq !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_hold got=%h/%b/%b want=0/0/0",
                 readdata, readdatavalid, wrap_irq);
      end
    end
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(); idle();
    end
    step(); bus(1, 0, 4'd5, 32'd0);
    step(); bus(1, 0, 4'd2, 32'd0);
    step(); idle();
  endtask

  initial begin
    test_reset();
    test_id_ts();
    test_atomic();
    test_wrap();
    test_scratch();
    test_freeze();
    test_random();
    test_reset_mid();
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      step(); idle();
    end
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
